// File: rtl/noc_link_credit_buffer.sv
// Credit-based elastic link stage: local FIFO, downstream credit counter, registered output.
// Optional NOC_LINK_STATS_EN adds flit/stall statistics counters with synchronous clear.
module noc_link_credit_buffer #(
  parameter int FLIT_WIDTH         = 64,
  parameter int DEST_WIDTH         = 6,
  parameter int BUFFER_DEPTH       = 8,
  parameter int DOWNSTREAM_CREDITS = 8,
  parameter int STAT_WIDTH         = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [FLIT_WIDTH-1:0] data_in,
  input  logic [DEST_WIDTH-1:0] dest_in,
  input  logic                  is_tail_in,
  input  logic                  send_in,
  output logic                  credit_out,
  output logic [FLIT_WIDTH-1:0] data_out,
  output logic [DEST_WIDTH-1:0] dest_out,
  output logic                  is_tail_out,
  output logic                  send_out,
  input  logic                  credit_in,
`ifdef NOC_LINK_STATS_EN
  input  logic                  stat_clear,
  output logic [STAT_WIDTH-1:0] stat_flits,
  output logic [STAT_WIDTH-1:0] stat_stall,
`endif
  output logic                  overflow_err,
  output logic                  credit_err
);

  localparam int PTR_W   = (BUFFER_DEPTH > 1) ? $clog2(BUFFER_DEPTH) : 1;
  localparam int OCC_W   = $clog2(BUFFER_DEPTH + 1);
  localparam int CNT_W   = $clog2(DOWNSTREAM_CREDITS + 1);
  localparam int ENTRY_W = FLIT_WIDTH + DEST_WIDTH + 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DOWNSTREAM_CREDITS);
  localparam logic [OCC_W-1:0] OCC_MAX = OCC_W'(BUFFER_DEPTH);

  logic [ENTRY_W-1:0]    mem_q [BUFFER_DEPTH];
  logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [OCC_W-1:0]      occ_q, occ_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  overflow_err_q, overflow_err_d;
  logic                  credit_err_q, credit_err_d;
  logic                  send_out_q, send_out_d;
  logic                  credit_out_q, credit_out_d;
  logic [FLIT_WIDTH-1:0] data_out_q, data_out_d;
  logic [DEST_WIDTH-1:0] dest_out_q, dest_out_d;
  logic                  is_tail_out_q, is_tail_out_d;

  logic                  fifo_nonempty, fifo_full, pop, push;
  logic [ENTRY_W-1:0]    head;

  always_comb begin
    fifo_nonempty = (occ_q != '0);
    fifo_full     = (occ_q == OCC_MAX);
    // Pop decision uses only the registered count; a same-cycle credit counts next cycle.
    pop           = fifo_nonempty & (cnt_q != '0);
    push          = send_in & (~fifo_full | pop);
    head          = mem_q[rd_ptr_q];
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    occ_d    = occ_q;
    if (push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    if (push && !pop)      occ_d = occ_q + 1'b1;
    else if (!push && pop) occ_d = occ_q - 1'b1;
  end

  always_comb begin
    cnt_d          = cnt_q;
    credit_err_d   = credit_err_q;
    overflow_err_d = overflow_err_q;
    if (pop && !credit_in) begin
      cnt_d = cnt_q - 1'b1;
    end else if (!pop && credit_in) begin
      if (cnt_q == CNT_MAX) credit_err_d = 1'b1;
      else                  cnt_d = cnt_q + 1'b1;
    end
    if (send_in && fifo_full && !pop) overflow_err_d = 1'b1;
  end

  always_comb begin
    send_out_d    = pop;
    credit_out_d  = pop;
    data_out_d    = data_out_q;
    dest_out_d    = dest_out_q;
    is_tail_out_d = is_tail_out_q;
    if (pop) begin
      data_out_d    = head[ENTRY_W-1 -: FLIT_WIDTH];
      dest_out_d    = head[DEST_WIDTH:1];
      is_tail_out_d = head[0];
    end
  end

  // FIFO storage carries no reset; occupancy and pointers define which entries are live.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= {data_in, dest_in, is_tail_in};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q       <= '0;
      rd_ptr_q       <= '0;
      occ_q          <= '0;
      cnt_q          <= CNT_MAX;
      overflow_err_q <= 1'b0;
      credit_err_q   <= 1'b0;
      send_out_q     <= 1'b0;
      credit_out_q   <= 1'b0;
      data_out_q     <= '0;
      dest_out_q     <= '0;
      is_tail_out_q  <= 1'b0;
    end else begin
      wr_ptr_q       <= wr_ptr_d;
      rd_ptr_q       <= rd_ptr_d;
      occ_q          <= occ_d;
      cnt_q          <= cnt_d;
      overflow_err_q <= overflow_err_d;
      credit_err_q   <= credit_err_d;
      send_out_q     <= send_out_d;
      credit_out_q   <= credit_out_d;
      data_out_q     <= data_out_d;
      dest_out_q     <= dest_out_d;
      is_tail_out_q  <= is_tail_out_d;
    end
  end

  assign credit_out   = credit_out_q;
  assign send_out     = send_out_q;
  assign data_out     = data_out_q;
  assign dest_out     = dest_out_q;
  assign is_tail_out  = is_tail_out_q;
  assign overflow_err = overflow_err_q;
  assign credit_err   = credit_err_q;

`ifdef NOC_LINK_STATS_EN
  logic [STAT_WIDTH-1:0] stat_flits_q, stat_flits_d;
  logic [STAT_WIDTH-1:0] stat_stall_q, stat_stall_d;

  always_comb begin
    stat_flits_d = stat_flits_q;
    stat_stall_d = stat_stall_q;
    if (stat_clear) begin
      stat_flits_d = '0;
      stat_stall_d = '0;
    end else begin
      if (send_out_q)                       stat_flits_d = stat_flits_q + 1'b1;
      if (fifo_nonempty && cnt_q == '0)     stat_stall_d = stat_stall_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_flits_q <= '0;
      stat_stall_q <= '0;
    end else begin
      stat_flits_q <= stat_flits_d;
      stat_stall_q <= stat_stall_d;
    end
  end

  assign stat_flits = stat_flits_q;
  assign stat_stall = stat_stall_q;
`endif

endmodule
